uart_tx_fifo: RTL

Buffered, parametrised UART transmitter for the memory-mapped store path of the RISC-V core. The datapath writes bytes at core speed through a chip-select strobe decoded from the store address. The block queues them in a FIFO and serialises them on `tx`. It supports configurable data width, parity, stop bits and baud divisor, with no gap between back-to-back frames. It reports FIFO level, full/empty and sticky overflow so the core can poll or stall.

---
 rtl/uart_tx_fifo.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// ----------------------------------------------------------------------------
// uart_tx_fifo
//
// Buffered UART transmitter for the memory-mapped store path. The core writes
// words through a chip-select strobe. They are queued in a small FIFO and
// serialised on tx as start / data (LSB first) / optional parity / stop bits.
// When another word is waiting at the end of a frame, the next frame starts
// with no idle gap.
//
// Ports
//   clk       in   single clock, rising edge
//   reset     in   synchronous, active-high; aborts any frame and flushes FIFO
//   cs        in   write strobe: enqueue wdata this cycle
//   wdata     in   [DATA_BITS] word to transmit
//   clr_ovf   in   clears the sticky overflow flag
//   tx        out  serial line, idles high
//   busy      out  high whenever the serialiser is not idle
//   done      out  one-cycle pulse on the last clock of a frame's final stop bit
//   full      out  level == FIFO_DEPTH
//   empty     out  level == 0
//   level     out  [$clog2(FIFO_DEPTH)+1] entries currently queued
//   overflow  out  sticky; set when a write hits a full FIFO
//
// Handshake: a write is accepted on any rising edge where cs is high and the
// registered full flag is low. There is no back-pressure signal besides full.
// A write that sees full is discarded and recorded in overflow.
//
// All outputs come straight from flops. There is no combinational path from
// any input to tx.
// ----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cs,
  input  logic [DATA_BITS-1:0]        wdata,
  input  logic                        clr_ovf,
  output logic                        tx,
  output logic                        busy,
  output logic                        done,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  // The cycle before the last one of a bit. done is a flop, so it must be
  // armed one cycle early to be high during the last clock of the stop bit.
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [LW-1:0]        level_nxt;
  logic                 push;
  logic                 pop;

  // Serialiser state, declared here because pop depends on it
  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shift;
  logic                 par;

  logic                 cnt_wrap;
  logic                 stop_last;
  logic                 frame_end;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  // full is the registered flag. A pop in the same cycle does not rescue a
  // write that arrives while full.
  assign push = cs && !full;

  assign cnt_wrap  = (cnt == CNT_LAST);
  assign stop_last = (STOP_BITS == 1) || stop_idx;
  assign frame_end = (state == STOP) && cnt_wrap && stop_last;

  // Pop happens when the serialiser is about to start a frame. It starts
  // either from idle, or directly at the end of the previous frame.
  assign pop = !empty && ((state == IDLE) || frame_end);

  assign head = mem[rd_ptr];
  // Parity is taken from the popped word. For odd parity, invert the XOR.
  assign head_par = (^head) ^ (PARITY == 2);

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LW'(1);
    end else if (pop && !push) begin
      level_nxt = level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of two.
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      level <= level_nxt;
      full  <= (level_nxt == LVL_FULL);
      empty <= (level_nxt == '0);
      // If a drop and a clear happen in the same cycle, the set wins.
      // This way a drop is never lost.
      if (cs && full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Serialiser FSM. tx, busy and done are registered together with state.
  // The value put on tx at each transition is the value of the bit being
  // entered.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shift    <= head;
            par      <= head_par;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (cnt_wrap) begin
            cnt   <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (cnt_wrap) begin
            cnt <= '0;
            if (bit_idx == BIT_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                tx    <= par;
                state <= PAR;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              // Shift one bit per bit time. The next bit is shift[1] now.
              bit_idx <= bit_idx + BW'(1);
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        PAR: begin
          if (cnt_wrap) begin
            cnt   <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          done <= stop_last && (cnt == CNT_PRE);
          if (cnt_wrap) begin
            cnt <= '0;
            if (stop_last) begin
              stop_idx <= 1'b0;
              if (!empty) begin
                // Back-to-back: the next start bit follows immediately.
                shift   <= head;
                par     <= head_par;
                bit_idx <= '0;
                tx      <= 1'b0;
                state   <= START;
              end else begin
                tx    <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
